// File: rtl/zuma_config_loader_if.sv
// Configuration stream and overlay configuration port for zuma_config_loader.
// The master modport is the loader side; slave is the source/overlay side.
interface zuma_config_loader_if #(
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32
);
  logic                    start;
  logic [CONFIG_WIDTH-1:0] cfg_data_in;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CONFIG_WIDTH-1:0] config_data;
  logic [ADDR_WIDTH-1:0]   config_addr;
  logic                    config_en;
  logic                    ffrst;
  logic                    busy;
  logic                    done;
  logic [ADDR_WIDTH-1:0]   progress;

  modport master (
    input  start, cfg_data_in, cfg_valid,
    output cfg_ready, config_data, config_addr, config_en,
    output ffrst, busy, done, progress
  );

  modport slave (
    output start, cfg_data_in, cfg_valid,
    input  cfg_ready, config_data, config_addr, config_en,
    input  ffrst, busy, done, progress
  );
endinterface

// File: rtl/zuma_config_loader.sv
// Streams N configuration words into the ZUMA overlay at sequential addresses,
// then holds the overlay's virtual flip-flop reset for VRESET_CYCLES cycles.
module zuma_config_loader #(
  parameter int CONFIG_WIDTH  = 32,
  parameter int LUT_SIZE      = 6,
  parameter int NUM_STAGES    = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int VRESET_CYCLES = 2,
  parameter bit REVERSE_BITS  = 1'b1,
  parameter bit AUTO_START    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  zuma_config_loader_if.master  bus
);

  localparam int unsigned N_WORDS = (2 ** LUT_SIZE) * NUM_STAGES;
  localparam int VCNT_W = $clog2(VRESET_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(N_WORDS - 1);
  localparam logic [VCNT_W-1:0] VCNT_END = VCNT_W'(VRESET_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VRST, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic [VCNT_W-1:0]       vcnt_q, vcnt_d;
  logic                    auto_q, auto_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CONFIG_WIDTH-1:0] data_q, data_d;
  logic                    hs;

  function automatic logic [CONFIG_WIDTH-1:0] order_bits(input logic [CONFIG_WIDTH-1:0] w);
    logic [CONFIG_WIDTH-1:0] r;
    r = w;
    if (REVERSE_BITS) begin
      for (int i = 0; i < CONFIG_WIDTH; i++) r[CONFIG_WIDTH-1-i] = w[i];
    end
    return r;
  endfunction

  // A restart request wins over a handshake in the same cycle.
  assign hs = (state_q == S_LOAD) && bus.cfg_valid && !bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      vcnt_q  <= '0;
      auto_q  <= AUTO_START;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vcnt_q  <= vcnt_d;
      auto_q  <= auto_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    vcnt_d  = '0;
    auto_d  = 1'b0;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (bus.start) begin
      state_d = S_LOAD;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (auto_q) begin
            state_d = S_LOAD;
            count_d = '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            count_d = count_q + ADDR_WIDTH'(1);
            if (count_q == LAST_WORD) state_d = S_VRST;
          end
        end
        // vcnt 0 is the gap cycle after the last write; 1..VRESET_CYCLES drive ffrst.
        S_VRST: begin
          if (vcnt_q == VCNT_END) state_d = S_DONE;
          else                    vcnt_d  = vcnt_q + VCNT_W'(1);
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (hs) begin
      en_d   = 1'b1;
      addr_d = count_q;
      data_d = order_bits(bus.cfg_data_in);
    end
  end

  always_comb begin
    bus.cfg_ready   = (state_q == S_LOAD);
    bus.busy        = (state_q == S_LOAD) || (state_q == S_VRST);
    bus.done        = (state_q == S_DONE);
    bus.ffrst       = (state_q == S_VRST) && (vcnt_q != '0);
    bus.config_en   = en_q;
    bus.config_addr = addr_q;
    bus.config_data = data_q;
    bus.progress    = count_q;
  end

endmodule

// File: tb/tb_zuma_config_loader.sv
// Directed bench for zuma_config_loader: dut_a auto-starts with bit reversal,
// dut_b waits for start and passes data straight through. Both use N=8 words.
module tb_zuma_config_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  zuma_config_loader_if #(.CONFIG_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
  zuma_config_loader_if #(.CONFIG_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

  zuma_config_loader #(
    .CONFIG_WIDTH(32), .LUT_SIZE(2), .NUM_STAGES(2), .ADDR_WIDTH(32),
    .VRESET_CYCLES(2), .REVERSE_BITS(1'b1), .AUTO_START(1'b1)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  zuma_config_loader #(
    .CONFIG_WIDTH(32), .LUT_SIZE(2), .NUM_STAGES(2), .ADDR_WIDTH(32),
    .VRESET_CYCLES(2), .REVERSE_BITS(1'b0), .AUTO_START(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  function automatic logic [31:0] rev32(input logic [31:0] v);
    return {<<{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus_a.cfg_ready, bus_a.config_en, bus_a.ffrst, bus_a.busy, bus_a.done,
         bus_a.config_addr, bus_a.config_data, bus_a.progress} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got ready=%b en=%b ffrst=%b busy=%b done=%b addr=%h data=%h prog=%h, expected all 0",
               bus_a.cfg_ready, bus_a.config_en, bus_a.ffrst, bus_a.busy, bus_a.done,
               bus_a.config_addr, bus_a.config_data, bus_a.progress);
    end
    n_tests++;
    if ({bus_b.cfg_ready, bus_b.config_en, bus_b.ffrst, bus_b.busy, bus_b.done,
         bus_b.config_addr, bus_b.config_data, bus_b.progress} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got ready=%b en=%b busy=%b done=%b, expected all 0",
               bus_b.cfg_ready, bus_b.config_en, bus_b.busy, bus_b.done);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({bus_a.cfg_ready, bus_a.busy, bus_a.done, bus_a.config_en, bus_a.ffrst} !== 5'b11000) begin
      n_fail++;
      $display("FAIL auto_start_a: got ready,busy,done,en,ffrst=%b, expected 11000",
               {bus_a.cfg_ready, bus_a.busy, bus_a.done, bus_a.config_en, bus_a.ffrst});
    end
    n_tests++;
    if ({bus_b.cfg_ready, bus_b.busy, bus_b.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_auto_start_b: got ready,busy,done=%b, expected 000",
               {bus_b.cfg_ready, bus_b.busy, bus_b.done});
    end
  endtask

  task automatic test_nominal();
    bus_a.cfg_valid   = 1'b1;
    bus_a.cfg_data_in = 32'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if ({bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress} !==
          {1'b1, 32'(i), rev32(32'(i + 1)), 32'(i + 1)}) begin
        n_fail++;
        $display("FAIL nominal_write%0d: got en=%b addr=%0d data=%h prog=%0d, expected en=1 addr=%0d data=%h prog=%0d",
                 i, bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress,
                 i, rev32(32'(i + 1)), i + 1);
      end
      if (i == 0) begin
        n_tests++;
        if (bus_a.config_data !== 32'h8000_0000) begin
          n_fail++;
          $display("FAIL bit_order_reversed: got %h, expected 80000000", bus_a.config_data);
        end
      end
      bus_a.cfg_data_in = 32'(i + 2);
    end
    n_tests++;
    if ({bus_a.cfg_ready, bus_a.busy, bus_a.ffrst, bus_a.done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL nominal_after_last: got ready,busy,ffrst,done=%b, expected 0100",
               {bus_a.cfg_ready, bus_a.busy, bus_a.ffrst, bus_a.done});
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_tests++;
      if ({bus_a.config_en, bus_a.cfg_ready, bus_a.ffrst, bus_a.done, bus_a.busy, bus_a.progress} !==
          {1'b0, 1'b0, (j < 2), (j >= 2), (j < 2), 32'd8}) begin
        n_fail++;
        $display("FAIL nominal_completion%0d: got en=%b ready=%b ffrst=%b done=%b busy=%b prog=%0d, expected ffrst=%b done=%b busy=%b prog=8",
                 j, bus_a.config_en, bus_a.cfg_ready, bus_a.ffrst, bus_a.done, bus_a.busy,
                 bus_a.progress, (j < 2), (j >= 2), (j < 2));
      end
    end
    bus_a.cfg_valid = 1'b0;
  endtask

  task automatic test_reprogram_backpressure();
    int          wcount;
    int          c;
    logic        pv;
    logic [31:0] pd;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    n_tests++;
    if ({bus_a.done, bus_a.busy, bus_a.cfg_ready, bus_a.progress} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL reprogram_entry: got done=%b busy=%b ready=%b prog=%0d, expected 0 1 1 0",
               bus_a.done, bus_a.busy, bus_a.cfg_ready, bus_a.progress);
    end
    wcount    = 0;
    c         = 0;
    last_addr = 32'd7;
    last_data = rev32(32'd8);
    while (wcount < 8 && c < 60) begin
      bus_a.cfg_valid   = (c % 3 == 0);
      bus_a.cfg_data_in = 32'h100 + 32'(c);
      pv = bus_a.cfg_valid;
      pd = bus_a.cfg_data_in;
      tick();
      c++;
      n_tests++;
      if (pv) begin
        if ({bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress} !==
            {1'b1, 32'(wcount), rev32(pd), 32'(wcount + 1)}) begin
          n_fail++;
          $display("FAIL bp_write%0d: got en=%b addr=%0d data=%h prog=%0d, expected en=1 addr=%0d data=%h prog=%0d",
                   wcount, bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress,
                   wcount, rev32(pd), wcount + 1);
        end
        last_addr = 32'(wcount);
        last_data = rev32(pd);
        wcount++;
      end else begin
        if ({bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress} !==
            {1'b0, last_addr, last_data, 32'(wcount)}) begin
          n_fail++;
          $display("FAIL bp_gap_c%0d: got en=%b addr=%0d data=%h prog=%0d, expected en=0 addr=%0d data=%h prog=%0d",
                   c, bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress,
                   last_addr, last_data, wcount);
        end
      end
    end
    bus_a.cfg_valid = 1'b0;
    n_tests++;
    if (wcount !== 8) begin
      n_fail++;
      $display("FAIL bp_word_count: got %0d writes, expected 8", wcount);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_tests++;
      if ({bus_a.config_en, bus_a.ffrst, bus_a.done} !== {1'b0, (j < 2), (j == 2)}) begin
        n_fail++;
        $display("FAIL bp_completion%0d: got en=%b ffrst=%b done=%b, expected en=0 ffrst=%b done=%b",
                 j, bus_a.config_en, bus_a.ffrst, bus_a.done, (j < 2), (j == 2));
      end
    end
  endtask

  task automatic test_restart();
    bus_a.start = 1'b1;
    tick();
    bus_a.start     = 1'b0;
    bus_a.cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_a.cfg_data_in = 32'(i + 1);
      tick();
      n_tests++;
      if ({bus_a.config_en, bus_a.config_addr} !== {1'b1, 32'(i)}) begin
        n_fail++;
        $display("FAIL restart_pre%0d: got en=%b addr=%0d, expected en=1 addr=%0d",
                 i, bus_a.config_en, bus_a.config_addr, i);
      end
    end
    bus_a.start       = 1'b1;
    bus_a.cfg_data_in = 32'd6;
    tick();
    bus_a.start = 1'b0;
    n_tests++;
    if ({bus_a.config_en, bus_a.progress, bus_a.config_addr, bus_a.cfg_ready, bus_a.busy} !==
        {1'b0, 32'd0, 32'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_discard: got en=%b prog=%0d addr=%0d ready=%b busy=%b, expected en=0 prog=0 addr=4 ready=1 busy=1",
               bus_a.config_en, bus_a.progress, bus_a.config_addr, bus_a.cfg_ready, bus_a.busy);
    end
    for (int i = 0; i < 8; i++) begin
      bus_a.cfg_data_in = 32'(50 + i);
      tick();
      n_tests++;
      if ({bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress} !==
          {1'b1, 32'(i), rev32(32'(50 + i)), 32'(i + 1)}) begin
        n_fail++;
        $display("FAIL restart_write%0d: got en=%b addr=%0d data=%h prog=%0d, expected en=1 addr=%0d data=%h prog=%0d",
                 i, bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress,
                 i, rev32(32'(50 + i)), i + 1);
      end
    end
    bus_a.cfg_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_tests++;
      if ({bus_a.ffrst, bus_a.done, bus_a.progress} !== {(j < 2), (j == 2), 32'd8}) begin
        n_fail++;
        $display("FAIL restart_completion%0d: got ffrst=%b done=%b prog=%0d, expected ffrst=%b done=%b prog=8",
                 j, bus_a.ffrst, bus_a.done, bus_a.progress, (j < 2), (j == 2));
      end
    end
  endtask

  task automatic test_reset_midload();
    bus_a.start = 1'b1;
    tick();
    bus_a.start     = 1'b0;
    bus_a.cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.cfg_data_in = 32'(i + 1);
      tick();
    end
    n_tests++;
    if ({bus_a.config_en, bus_a.config_addr} !== {1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL midload_pre: got en=%b addr=%0d, expected en=1 addr=2",
               bus_a.config_en, bus_a.config_addr);
    end
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus_a.cfg_ready, bus_a.config_en, bus_a.ffrst, bus_a.busy, bus_a.done,
         bus_a.config_addr, bus_a.config_data, bus_a.progress} !== '0) begin
      n_fail++;
      $display("FAIL midload_async_reset: got ready=%b en=%b busy=%b addr=%0d data=%h prog=%0d, expected all 0",
               bus_a.cfg_ready, bus_a.config_en, bus_a.busy, bus_a.config_addr,
               bus_a.config_data, bus_a.progress);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    tick();
    n_tests++;
    if ({bus_a.cfg_ready, bus_a.busy, bus_a.config_en, bus_a.progress} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL midload_restart: got ready=%b busy=%b en=%b prog=%0d, expected 1 1 0 0",
               bus_a.cfg_ready, bus_a.busy, bus_a.config_en, bus_a.progress);
    end
    bus_a.cfg_data_in = 32'd77;
    tick();
    n_tests++;
    if ({bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress} !==
        {1'b1, 32'd0, rev32(32'd77), 32'd1}) begin
      n_fail++;
      $display("FAIL midload_first_write: got en=%b addr=%0d data=%h prog=%0d, expected en=1 addr=0 data=%h prog=1",
               bus_a.config_en, bus_a.config_addr, bus_a.config_data, bus_a.progress, rev32(32'd77));
    end
    bus_a.cfg_valid = 1'b0;
  endtask

  task automatic test_idle_hold();
    bus_b.cfg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_b.cfg_data_in = 32'(i + 3);
      tick();
      n_tests++;
      if ({bus_b.config_en, bus_b.cfg_ready, bus_b.busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_hold%0d: got en,ready,busy=%b, expected 000",
                 i, {bus_b.config_en, bus_b.cfg_ready, bus_b.busy});
      end
    end
    bus_b.cfg_valid = 1'b0;
  endtask

  task automatic test_bit_order();
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    n_tests++;
    if ({bus_b.cfg_ready, bus_b.busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_b: got ready,busy=%b, expected 11", {bus_b.cfg_ready, bus_b.busy});
    end
    bus_b.cfg_valid   = 1'b1;
    bus_b.cfg_data_in = 32'h0000_0001;
    tick();
    bus_b.cfg_valid = 1'b0;
    n_tests++;
    if ({bus_b.config_en, bus_b.config_addr, bus_b.config_data} !== {1'b1, 32'd0, 32'h0000_0001}) begin
      n_fail++;
      $display("FAIL bit_order_straight: got en=%b addr=%0d data=%h, expected en=1 addr=0 data=00000001",
               bus_b.config_en, bus_b.config_addr, bus_b.config_data);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus_a.start       = 1'b0;
    bus_a.cfg_valid   = 1'b0;
    bus_a.cfg_data_in = '0;
    bus_b.start       = 1'b0;
    bus_b.cfg_valid   = 1'b0;
    bus_b.cfg_data_in = '0;
    test_reset();
    test_nominal();
    test_reprogram_backpressure();
    test_restart();
    test_reset_midload();
    test_idle_hold();
    test_bit_order();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/zuma_config_loader.md
# zuma_config_loader

Parametrised configuration controller for the ZUMA overlay. It streams configuration words from an external source over a valid/ready handshake, writes them to the overlay's configuration port at sequential addresses with optional bit reversal, then pulses the overlay's virtual flip-flop reset for a programmable number of cycles. It supports reprogramming on demand, restart mid-load, and status and progress reporting. It sits between a configuration store or host link and the `ZUMA_custom_generated` overlay instance.

## Interface
- `CONFIG_WIDTH`, 32: width of one configuration word.
- `LUT_SIZE`, 6: overlay LUT input count; one stage holds 2**LUT_SIZE words.
- `NUM_STAGES`, 8: number of configuration stages. Total words N = (2**LUT_SIZE)*NUM_STAGES.
- `ADDR_WIDTH`, 32: width of `config_addr` and `progress`. Must hold N.
- `VRESET_CYCLES`, 2: length of the `ffrst` pulse in cycles, minimum 1.
- `REVERSE_BITS`, 1: 1 means `config_data[CONFIG_WIDTH-1-i] = cfg_data_in[i]`; 0 means pass straight through.
- `AUTO_START`, 1: 1 means a load begins automatically after reset.

- `clk`, in, 1: clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a (re)load. Sampled every cycle.
- `cfg_data_in`, in, CONFIG_WIDTH: source configuration word.
- `cfg_valid`, in, 1: `cfg_data_in` is valid.
- `cfg_ready`, out, 1: the loader accepts a word this cycle.
- `config_data`, out, CONFIG_WIDTH: word to the overlay, reversed when `REVERSE_BITS`=1.
- `config_addr`, out, ADDR_WIDTH: overlay write address.
- `config_en`, out, 1: overlay write strobe.
- `ffrst`, out, 1: virtual reset to the overlay flip-flops.
- `busy`, out, 1: high in LOAD or VRST.
- `done`, out, 1: high in DONE. The overlay is configured and running.
- `progress`, out, ADDR_WIDTH: number of words written in the current load.

## Operation
States: IDLE, LOAD, VRST, DONE. The reset state is IDLE.

While `reset` is high, all outputs are 0: `cfg_ready`, `config_en`, `config_addr`, `config_data`, `ffrst`, `busy`, `done`, `progress`. The word counter and the ffrst counter are also cleared.

Transitions:
- IDLE to LOAD: on `start`, or on the first edge after reset deassertion when `AUTO_START`=1. The word counter is cleared.
- LOAD: `cfg_ready`=1. A handshake occurs in a cycle where `cfg_valid` and `cfg_ready` are both high. On each handshake:
  - `config_en` = 1
  - `config_addr` = count
  - `config_data` = (reversed) data
  - count = count+1
  - `progress` = count+1

  A cycle without a handshake gives `config_en`=0; `config_addr` and `config_data` hold. `cfg_data_in` is not required to be stable across stalls.
- LOAD to VRST: on the handshake of word N-1 (count reaches N).
- VRST: `ffrst`=1 for exactly `VRESET_CYCLES` cycles, then move to DONE.
- DONE: `done`=1 and `ffrst`=0. Hold until `start`.
- `start` in LOAD, VRST or DONE: restart. Next state is LOAD with count=0, `progress`=0 and `done`=0. `ffrst` is forced to 0.
  - A handshake in the same cycle as `start` is discarded: no write occurs.
- `start` in LOAD has priority over completing word N-1.
- `cfg_valid` in IDLE, VRST or DONE is ignored; `cfg_ready`=0 in those states.
- Asserting `reset` mid-load aborts immediately, asynchronously. No partial `config_en` pulse survives reset.
- Address arithmetic is unsigned, zero-extended to ADDR_WIDTH. No wrap occurs because the load ends at N.

## Timing
- `cfg_ready` is a registered state decode: it is high from the edge after entry to LOAD, and low from the edge that accepts word N-1.
- Write latency is 1 cycle. A handshake sampled at edge k produces `config_en`, `config_addr` and `config_data` valid after edge k, for one cycle.
- With `cfg_valid` held high, all N words are written on N consecutive cycles.
- Last handshake at edge k:
  - `config_en`=1 after edge k.
  - `ffrst`=1 after edges k+1 through k+VRESET_CYCLES.
  - `done`=1 and `ffrst`=0 after edge k+VRESET_CYCLES+1.
- `busy` = LOAD or VRST, registered together with the state.
- With `AUTO_START`=1 and reset deasserted before edge r, `cfg_ready`=1 after edge r.

## Test plan
- Nominal: `LUT_SIZE`=2, `NUM_STAGES`=2 (N=8), `VRESET_CYCLES`=2, `cfg_valid` held high, data 1..8. Required response:
  - 8 consecutive `config_en` pulses with addresses 0..7.
  - `ffrst` high for exactly 2 cycles after the last write, then `done`=1.
  - `progress`=8.
- Backpressure: same parameters, `cfg_valid` toggling 1,0,0,1,... Required response:
  - `config_en` only on handshake cycles.
  - Addresses contiguous 0..7, `config_addr` held during gaps.
  - The completion sequence is unchanged.
- Bit order: `CONFIG_WIDTH`=32, input 0x00000001.
  - With `REVERSE_BITS`=1, `config_data`=0x80000000.
  - With `REVERSE_BITS`=0, `config_data`=0x00000001.
- Restart: `start` asserted after 5 words, with a handshake in the same cycle. Required response:
  - No write in that cycle; `progress` returns to 0.
  - The next write is at address 0.
  - 8 further writes, then a normal `ffrst` pulse and `done`.
- Reset mid-load: assert `reset` asynchronously between edges after 3 words. Required response:
  - All outputs go to 0 immediately.
  - After deassertion with `AUTO_START`=1, `cfg_ready`=1 one edge later and the load restarts at address 0.
- Reprogram from DONE: pulse `start`. Required response:
  - `done`=0 and `busy`=1 after the next edge.
  - A full 8-word load and completion sequence follows.
- IDLE hold (`AUTO_START`=0): `cfg_valid` held high for 10 cycles without `start`. Required response: no `config_en`, `cfg_ready`=0, `busy`=0.
